// File: rtl/ooop_types.sv
// Shared core types: ROB sizing plus the commit-monitor state, halt cause and trace record.
package ooop_types;

  localparam int unsigned ROB_TAG_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    MAXCYC = 2'd1,
    STALL  = 2'd2,
    EXT    = 2'd3
  } halt_cause_e;

  typedef struct packed {
    logic [31:0]          cycle;
    logic [ROB_TAG_W-1:0] tag;
    logic                 rd_used;
    logic [4:0]           rd;
    logic [31:0]          value;
  } trace_rec_t;

  localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data comes straight from
// the storage registers, so a pushed entry is visible the cycle after the push.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status flags and handshake qualification; a push into a full FIFO is
  // still taken when a pop frees the slot in the same cycle.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr[AW-1:0]];
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/commit_monitor.sv
// Commit-side observer: counters, a0/a1 shadows, trace FIFO and run-control FSM.
module commit_monitor
  import ooop_types::*;
#(
  parameter int unsigned MAX_CYCLES      = 300,
  parameter int unsigned STALL_THRESHOLD = 200,
  parameter int unsigned TRACE_DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 halt_req,
  input  logic                 commit_v,
  input  logic [ROB_TAG_W-1:0] commit_tag,
  input  logic                 commit_rd_used,
  input  logic [4:0]           commit_rd,
  input  logic [31:0]          commit_value,
  input  logic                 flush,
  input  logic                 recover,
  output logic [31:0]          cycle_count,
  output logic [31:0]          commit_count,
  output logic [31:0]          stall_ctr,
  output logic [31:0]          recov_count,
  output logic [31:0]          a0_shadow,
  output logic [31:0]          a1_shadow,
  output mon_state_e           state_o,
  output logic                 halt_o,
  output halt_cause_e          halt_cause,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output trace_rec_t           trace_rec,
  output logic [15:0]          trace_drops
);

  mon_state_e  state;
  mon_state_e  state_next;
  halt_cause_e halt_sel;
  logic        active;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  trace_rec_t  push_rec;
  logic [TRACE_REC_W-1:0] fifo_rdata;

  // Halt arbitration on registered counters. The halt edge itself is not an
  // active cycle, so every counter freezes at the value that tripped it.
  always_comb begin
    halt_sel = NONE;
    if (halt_req)                             halt_sel = EXT;
    else if (stall_ctr >= 32'(STALL_THRESHOLD)) halt_sel = STALL;
    else if (cycle_count >= 32'(MAX_CYCLES))  halt_sel = MAXCYC;
    active   = (state == RUN) && (halt_sel == NONE);
    push     = active && commit_v;
    pop      = trace_valid && trace_ready;
    push_rec = '{cycle: cycle_count, tag: commit_tag, rd_used: commit_rd_used,
                 rd: commit_rd, value: commit_value};
  end

  // Next-state and status outputs.
  always_comb begin
    state_next  = state;
    halt_o      = (state == HALTED);
    state_o     = state;
    trace_valid = !fifo_empty;
    trace_rec   = trace_rec_t'(fifo_rdata);
    unique case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (halt_sel != NONE) state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // State register and halt-cause latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      halt_cause <= NONE;
    end else begin
      state <= state_next;
      if (state == RUN && halt_sel != NONE) halt_cause <= halt_sel;
    end
  end

  // Counters and architectural shadows, updated only in active RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count  <= '0;
      commit_count <= '0;
      stall_ctr    <= '0;
      recov_count  <= '0;
      a0_shadow    <= '0;
      a1_shadow    <= '0;
    end else if (active) begin
      cycle_count <= cycle_count + 32'd1;
      if (commit_v) begin
        commit_count <= commit_count + 32'd1;
        stall_ctr    <= '0;
      end else if (stall_ctr != '1) begin
        stall_ctr <= stall_ctr + 32'd1;
      end
      if (flush || recover) recov_count <= recov_count + 32'd1;
      if (commit_v && commit_rd_used && commit_rd == 5'd10) a0_shadow <= commit_value;
      if (commit_v && commit_rd_used && commit_rd == 5'd11) a1_shadow <= commit_value;
    end
  end

  // Saturating count of trace records refused by a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_drops <= '0;
    end else if (push && fifo_full && !pop && trace_drops != '1) begin
      trace_drops <= trace_drops + 16'd1;
    end
  end

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_REC_W)
  ) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_commit_monitor.sv
// Directed bench for commit_monitor with a small budget, threshold and FIFO.
module tb_commit_monitor;
  import ooop_types::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 halt_req;
  logic                 commit_v;
  logic [ROB_TAG_W-1:0] commit_tag;
  logic                 commit_rd_used;
  logic [4:0]           commit_rd;
  logic [31:0]          commit_value;
  logic                 flush;
  logic                 recover;
  logic [31:0]          cycle_count, commit_count, stall_ctr, recov_count;
  logic [31:0]          a0_shadow, a1_shadow;
  mon_state_e           state_o;
  logic                 halt_o;
  halt_cause_e          halt_cause;
  logic                 trace_valid;
  logic                 trace_ready;
  trace_rec_t           trace_rec;
  logic [15:0]          trace_drops;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n;

  commit_monitor #(
    .MAX_CYCLES      (20),
    .STALL_THRESHOLD (5),
    .TRACE_DEPTH     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .halt_req       (halt_req),
    .commit_v       (commit_v),
    .commit_tag     (commit_tag),
    .commit_rd_used (commit_rd_used),
    .commit_rd      (commit_rd),
    .commit_value   (commit_value),
    .flush          (flush),
    .recover        (recover),
    .cycle_count    (cycle_count),
    .commit_count   (commit_count),
    .stall_ctr      (stall_ctr),
    .recov_count    (recov_count),
    .a0_shadow      (a0_shadow),
    .a1_shadow      (a1_shadow),
    .state_o        (state_o),
    .halt_o         (halt_o),
    .halt_cause     (halt_cause),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_rec      (trace_rec),
    .trace_drops    (trace_drops)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; halt_req = 1'b0; commit_v = 1'b0;
    commit_tag = '0; commit_rd_used = 1'b0; commit_rd = '0; commit_value = '0;
    flush = 1'b0; recover = 1'b0; trace_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic commit_one(input logic used, input logic [4:0] rd, input logic [31:0] val);
    commit_v = 1'b1; commit_rd_used = used; commit_rd = rd; commit_value = val;
    commit_tag = val[ROB_TAG_W-1:0];
    tick();
    commit_v = 1'b0;
  endtask

  task automatic check_idle_reset(input string pfx);
    check_eq({pfx, "_state"}, 64'(state_o), 64'(IDLE));
    check_eq({pfx, "_cyc"},   64'(cycle_count), 64'd0);
    check_eq({pfx, "_cmt"},   64'(commit_count), 64'd0);
    check_eq({pfx, "_stall"}, 64'(stall_ctr), 64'd0);
    check_eq({pfx, "_recov"}, 64'(recov_count), 64'd0);
    check_eq({pfx, "_a0"},    64'(a0_shadow), 64'd0);
    check_eq({pfx, "_drops"}, 64'(trace_drops), 64'd0);
    check_eq({pfx, "_cause"}, 64'(halt_cause), 64'd0);
    check_eq({pfx, "_halt"},  64'(halt_o), 64'd0);
    check_eq({pfx, "_valid"}, 64'(trace_valid), 64'd0);
  endtask

  initial begin
    // Reset state.
    do_reset();
    check_idle_reset("rst");

    // Cycle budget halt with a commit every cycle and a ready drain port.
    enable = 1'b1; commit_v = 1'b1; commit_rd_used = 1'b0; trace_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && !halt_o; c++) begin
      if (trace_valid && trace_ready) begin
        check_eq("t1_rec_cycle", 64'(trace_rec.cycle), 64'(n));
        n++;
      end
      tick();
    end
    commit_v = 1'b0;
    check_eq("t1_halt",   64'(halt_o), 64'd1);
    check_eq("t1_state",  64'(state_o), 64'(HALTED));
    check_eq("t1_cause",  64'(halt_cause), 64'(MAXCYC));
    check_eq("t1_cyc",    64'(cycle_count), 64'd20);
    check_eq("t1_cmt",    64'(commit_count), 64'd20);
    check_eq("t1_drained", 64'(n), 64'd20);
    check_eq("t1_drops",  64'(trace_drops), 64'd0);

    // Stall watchdog: three commits then silence.
    do_reset();
    trace_ready = 1'b1; enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) commit_one(1'b0, 5'd0, 32'(i));
    check_eq("t2_stall0", 64'(stall_ctr), 64'd0);
    for (int c = 0; c < 20 && stall_ctr != 32'd5; c++) tick();
    check_eq("t2_stall",  64'(stall_ctr), 64'd5);
    check_eq("t2_run",    64'(state_o), 64'(RUN));
    tick();
    check_eq("t2_drain",  64'(state_o), 64'(DRAIN));
    check_eq("t2_halt1",  64'(halt_o), 64'd0);
    check_eq("t2_cause",  64'(halt_cause), 64'(STALL));
    tick();
    check_eq("t2_halt2",  64'(halt_o), 64'd1);
    check_eq("t2_stallf", 64'(stall_ctr), 64'd5);
    check_eq("t2_cmt",    64'(commit_count), 64'd3);

    // Shadows, ignored IDLE commit, recovery counting.
    do_reset();
    trace_ready = 1'b1;
    commit_one(1'b1, 5'd10, 32'h55);
    check_eq("t3_idle_a0",  64'(a0_shadow), 64'd0);
    check_eq("t3_idle_cmt", 64'(commit_count), 64'd0);
    check_eq("t3_idle_vld", 64'(trace_valid), 64'd0);
    enable = 1'b1;
    tick();
    commit_one(1'b1, 5'd10, 32'h0000002A);
    check_eq("t3_a0",  64'(a0_shadow), 64'h2A);
    commit_one(1'b1, 5'd11, 32'hFFFFFFFF);
    check_eq("t3_a1",  64'(a1_shadow), 64'hFFFFFFFF);
    commit_one(1'b0, 5'd10, 32'h00001234);
    check_eq("t3_a0_keep", 64'(a0_shadow), 64'h2A);
    check_eq("t3_a1_keep", 64'(a1_shadow), 64'hFFFFFFFF);
    check_eq("t3_cmt",     64'(commit_count), 64'd3);
    flush = 1'b1; recover = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    recover = 1'b0;
    check_eq("t3_recov", 64'(recov_count), 64'd2);

    // Overflow: six commits into a four-entry FIFO with the port stalled.
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) commit_one(1'b1, 5'd3, 32'(100 + i));
    check_eq("t4_drops", 64'(trace_drops), 64'd2);
    check_eq("t4_hold_vld", 64'(trace_valid), 64'd1);
    check_eq("t4_hold_val", 64'(trace_rec.value), 64'd100);
    tick();
    check_eq("t4_stable", 64'(trace_rec.value), 64'd100);
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_vld", 64'(trace_valid), 64'd1);
      check_eq("t4_val", 64'(trace_rec.value), 64'(100 + i));
      check_eq("t4_cyc", 64'(trace_rec.cycle), 64'(i));
      tick();
    end
    check_eq("t4_empty", 64'(trace_valid), 64'd0);

    // Full FIFO with a simultaneous push and pop.
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) commit_one(1'b0, 5'd0, 32'(200 + i));
    trace_ready = 1'b1;
    commit_one(1'b0, 5'd0, 32'd204);
    check_eq("t5_drops0", 64'(trace_drops), 64'd0);
    trace_ready = 1'b0;
    commit_one(1'b0, 5'd0, 32'd205);
    check_eq("t5_drops1", 64'(trace_drops), 64'd1);
    trace_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_val", 64'(trace_rec.value), 64'(201 + i));
      tick();
    end
    check_eq("t5_empty", 64'(trace_valid), 64'd0);

    // External request coincident with the stall condition, then reset mid-DRAIN.
    do_reset();
    enable = 1'b1;
    tick();
    commit_one(1'b0, 5'd0, 32'd1);
    commit_one(1'b0, 5'd0, 32'd2);
    for (int c = 0; c < 20 && stall_ctr != 32'd4; c++) tick();
    check_eq("t6_stall4", 64'(stall_ctr), 64'd4);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("t6_state", 64'(state_o), 64'(DRAIN));
    check_eq("t6_cause", 64'(halt_cause), 64'(EXT));
    tick();
    check_eq("t6_hold",  64'(state_o), 64'(DRAIN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("t6_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
